minterm_sweep_ctrl: RTL and testbench

MINTERM_SWEEP_CTRL -- requirements
Module: minterm_sweep_ctrl

---
 rtl/minterm_pkg.sv | 16 +
 rtl/popcount8.sv | 18 +
 rtl/minterm_sweep_ctrl.sv | 121 ++++++++++++
 tb/tb_minterm_sweep_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/minterm_pkg.sv
// Shared definitions for the minterm sweep controller.
//   state_t        : sweep sequencer states
//   MASK_DEFAULT_C : expected 3-input minterm mask after reset (minterms 0,2,4,6,7)
//   N_MINTERMS     : number of minterms of a 3-input function
package minterm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0]  MASK_DEFAULT_C = 8'hD5;
  localparam int unsigned N_MINTERMS     = 8;

endpackage

// File: rtl/popcount8.sv
// Combinational population count of an 8-bit vector.
//   bits  : input vector
//   count : number of set bits, 0..8
module popcount8
  import minterm_pkg::*;
(
  input  logic [7:0] bits,
  output logic [3:0] count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < N_MINTERMS; i++) begin
      count = count + {3'b000, bits[i]};
    end
  end

endmodule

// File: rtl/minterm_sweep_ctrl.sv
// Sweeps an external 3-input evaluator through all 8 minterms, captures its
// output per minterm, and compares the captured truth table with an
// expected mask.
//   Clock, Reset : rising-edge clock, synchronous active-high reset
//   start        : single-cycle request to begin a sweep (IDLE only)
//   mask_ld      : load mask_in as the expected mask (IDLE only)
//   mask_in      : new expected minterm mask
//   gate         : enable term ANDed with e_in, latched at start
//   e_in         : evaluator output for the current abc
//   abc          : evaluator inputs {a,b,c}, a = MSB
//   busy         : sweep in progress
//   done         : one-cycle completion pulse
//   result       : captured e_in per minterm
//   f_result     : captured e_in & gate_q per minterm
//   ones         : population count of result
//   match        : result equals the expected mask
module minterm_sweep_ctrl
  import minterm_pkg::*;
#(
  parameter logic [7:0] MASK_DEFAULT = MASK_DEFAULT_C
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic       mask_ld,
  input  logic [7:0] mask_in,
  input  logic       gate,
  input  logic       e_in,
  output logic [2:0] abc,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [7:0] f_result,
  output logic [3:0] ones,
  output logic       match
);

  state_t     state, state_nxt;
  logic       gate_q;
  logic [7:0] mask_q;
  logic [3:0] ones_q;
  logic       match_q;
  logic [3:0] pop;

  popcount8 u_popcount8 (
    .bits  (result),
    .count (pop)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = SWEEP;
      SWEEP: begin
        busy = 1'b1;
        if (abc == 3'd7) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      abc      <= '0;
      result   <= '0;
      f_result <= '0;
      gate_q   <= 1'b0;
      mask_q   <= MASK_DEFAULT;
      ones_q   <= '0;
      match_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mask_ld) mask_q <= mask_in;
          if (start) begin
            result   <= '0;
            f_result <= '0;
            gate_q   <= gate;
            abc      <= '0;
          end
        end
        SWEEP: begin
          result[abc]   <= e_in;
          f_result[abc] <= e_in & gate_q;
          abc           <= abc + 3'd1;  // 7 -> 0 on the last sample
        end
        DONE: begin
          ones_q  <= pop;
          match_q <= (result == mask_q);
        end
        default: ;
      endcase
    end
  end

  // During DONE the fresh summary is shown combinationally so it is valid
  // alongside the done pulse; the registered copy holds it afterwards.
  always_comb begin
    ones  = ones_q;
    match = match_q;
    if (state == DONE) begin
      ones  = pop;
      match = (result == mask_q);
    end
  end

endmodule

// File: tb/tb_minterm_sweep_ctrl.sv
module tb_minterm_sweep_ctrl;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       start;
  logic       mask_ld;
  logic [7:0] mask_in;
  logic       gate;
  logic       e_in;
  logic [2:0] abc;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] f_result;
  logic [3:0] ones;
  logic       match;

  // external evaluator: truth table indexed by {a,b,c}
  logic [7:0] eval_fn;
  assign e_in = eval_fn[abc];

  minterm_sweep_ctrl #(.MASK_DEFAULT(8'hD5)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .start    (start),
    .mask_ld  (mask_ld),
    .mask_in  (mask_in),
    .gate     (gate),
    .e_in     (e_in),
    .abc      (abc),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .f_result (f_result),
    .ones     (ones),
    .match    (match)
  );

  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: m_cnt counts cycles since an accepted start
  // (0 = idle, 1..8 = sweep step, 9 = completion cycle).
  int         m_cnt = 0;
  logic [7:0] m_res = '0, m_fres = '0, m_mask = 8'hD5;
  logic       m_gate = 1'b0;
  logic [3:0] m_ones = '0;
  logic       m_match = 1'b0;

  always @(posedge Clock) begin
    if (Reset) begin
      m_cnt = 0; m_res = '0; m_fres = '0; m_gate = 1'b0;
      m_mask = 8'hD5; m_ones = '0; m_match = 1'b0;
    end else if (m_cnt == 0) begin
      if (mask_ld) m_mask = mask_in;
      if (start) begin
        m_res = '0; m_fres = '0; m_gate = gate; m_cnt = 1;
      end
    end else if (m_cnt <= 8) begin
      m_res[m_cnt-1]  = eval_fn[m_cnt-1];
      m_fres[m_cnt-1] = eval_fn[m_cnt-1] & m_gate;
      m_cnt++;
    end else begin
      m_ones  = 4'($countones(m_res));
      m_match = (m_res == m_mask);
      m_cnt   = 0;
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      logic e_busy, e_done;
      e_busy = (m_cnt >= 1) && (m_cnt <= 8);
      e_done = (m_cnt == 9);
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("abc", 32'(abc), e_busy ? 32'(m_cnt - 1) : 32'd0);
      chk("result", 32'(result), 32'(m_res));
      chk("f_result", 32'(f_result), 32'(m_fres));
      chk("ones", 32'(ones), e_done ? 32'($countones(m_res)) : 32'(m_ones));
      chk("match", 32'(match), e_done ? 32'(m_res == m_mask) : 32'(m_match));
    end
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // kind: 0 none, 1 start pulse, 2 reset pulse, 3 gate toggle, 4 mask_ld pulse
  task automatic run_sweep(input logic g, input logic ld, input logic [7:0] mi,
                           input int act_cyc, input int kind, input logic [7:0] act_mask,
                           output int lat, output int ndone);
    lat = 0; ndone = 0;
    start = 1'b1; gate = g; mask_ld = ld; mask_in = mi;
    tick;
    start = 1'b0; mask_ld = 1'b0;
    for (int cyc = 2; cyc <= 14; cyc++) begin
      if (cyc == act_cyc) begin
        case (kind)
          1: start = 1'b1;
          2: Reset = 1'b1;
          3: gate = ~g;
          4: begin mask_ld = 1'b1; mask_in = act_mask; end
          default: ;
        endcase
      end else if (cyc == act_cyc + 1) begin
        start = 1'b0; Reset = 1'b0; mask_ld = 1'b0;
      end else if (cyc == act_cyc + 3) begin
        gate = g;
      end
      @(negedge Clock);
      if (done === 1'b1) begin
        ndone++;
        if (lat == 0) lat = cyc;
      end
      tick;
    end
  endtask

  int lat, nd;

  initial begin
    Reset = 1'b1; start = 1'b0; mask_ld = 1'b0; mask_in = '0; gate = 1'b0;
    eval_fn = 8'hD5;
    tick; tick;
    Reset = 1'b0;
    chk_en = 1'b1;
    @(negedge Clock);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ones", 32'(ones), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_abc", 32'(abc), 32'd0);
    tick;

    // default evaluator, gate=1
    run_sweep(1'b1, 1'b0, 8'h00, 0, 0, 8'h00, lat, nd);
    chk("t1_latency", 32'(lat), 32'd10);
    chk("t1_ndone", 32'(nd), 32'd1);
    chk("t1_result", 32'(result), 32'hD5);
    chk("t1_f_result", 32'(f_result), 32'hD5);
    chk("t1_ones", 32'(ones), 32'd5);
    chk("t1_match", 32'(match), 32'd1);

    // gate=0
    run_sweep(1'b0, 1'b0, 8'h00, 0, 0, 8'h00, lat, nd);
    chk("t2_result", 32'(result), 32'hD5);
    chk("t2_f_result", 32'(f_result), 32'h00);
    chk("t2_match", 32'(match), 32'd1);

    // mask load together with start
    run_sweep(1'b1, 1'b1, 8'hFF, 0, 0, 8'h00, lat, nd);
    chk("t3_match", 32'(match), 32'd0);
    chk("t3_ones", 32'(ones), 32'd5);

    // mask_ld during sweep is ignored (mask stays FF)
    eval_fn = 8'h3C;
    run_sweep(1'b1, 1'b0, 8'h00, 5, 4, 8'h3C, lat, nd);
    chk("t4_result", 32'(result), 32'h3C);
    chk("t4_ones", 32'(ones), 32'd4);
    chk("t4_match", 32'(match), 32'd0);
    // load in IDLE takes effect
    mask_ld = 1'b1; mask_in = 8'h3C; tick; mask_ld = 1'b0;
    run_sweep(1'b1, 1'b0, 8'h00, 0, 0, 8'h00, lat, nd);
    chk("t5_match", 32'(match), 32'd1);

    // start pulsed at sweep cycle 3 is ignored
    eval_fn = 8'hD5;
    run_sweep(1'b1, 1'b0, 8'h00, 4, 1, 8'h00, lat, nd);
    chk("t6_ndone", 32'(nd), 32'd1);
    chk("t6_latency", 32'(lat), 32'd10);
    chk("t6_result", 32'(result), 32'hD5);

    // reset at sweep cycle 4 aborts without done
    run_sweep(1'b1, 1'b0, 8'h00, 5, 2, 8'h00, lat, nd);
    chk("t7_ndone", 32'(nd), 32'd0);
    chk("t7_result", 32'(result), 32'd0);
    chk("t7_match", 32'(match), 32'd0);
    run_sweep(1'b1, 1'b0, 8'h00, 0, 0, 8'h00, lat, nd);
    chk("t8_latency", 32'(lat), 32'd10);
    chk("t8_match", 32'(match), 32'd1);

    // gate toggled mid-sweep has no effect
    run_sweep(1'b1, 1'b0, 8'h00, 4, 3, 8'h00, lat, nd);
    chk("t9_f_result", 32'(f_result), 32'hD5);
    chk("t9_result", 32'(result), 32'hD5);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
